// File: rtl/scan_ctrl.sv
// scan_ctrl: loads the scan chain MSB first and returns its old contents; SCAN_CAPTURE_EN adds a capture phase.
// done comes 2+2*DIV*CHAIN_LEN cycles after accept (+2*DIV with capture); start is ignored, not queued, while busy.
module scan_ctrl #(
  parameter int CHAIN_LEN = 16,
  parameter int DIV       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] wr_data,
`ifdef SCAN_CAPTURE_EN
  input  logic                 capture,
  output logic                 cap_clk,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] rd_data,
  output logic                 shift_en,
  output logic                 shift_clk,
  output logic                 scan_out,
  input  logic                 scan_in
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(CHAIN_LEN);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SH_LO   = 3'd2,
    ST_SH_HI   = 3'd3,
    ST_FINISH  = 3'd4
`ifdef SCAN_CAPTURE_EN
    , ST_CAPTURE = 3'd5
`endif
  } state_e;

  state_e                 state_q;
  logic [PW-1:0]          ph_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [CHAIN_LEN-1:0]   tx_sr_q;
  logic [CHAIN_LEN-1:0]   rx_sr_q;
  logic [CHAIN_LEN-1:0]   rd_data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   shift_en_q;
  logic                   shift_clk_q;
  logic                   scan_out_q;
`ifdef SCAN_CAPTURE_EN
  logic                   cap_clk_q;
`endif

  logic [PW-1:0]          ph_d;
  logic [BW-1:0]          bit_cnt_d;
  logic [CHAIN_LEN-1:0]   tx_sr_d;
  logic [CHAIN_LEN-1:0]   rx_sr_d;
  logic                   ph_last;

  assign ph_d      = ph_q + PW'(1);
  assign bit_cnt_d = bit_cnt_q + BW'(1);
  assign tx_sr_d   = {tx_sr_q[CHAIN_LEN-2:0], 1'b0};
  // The tail flop's old value arrives first, so it ends up in the MSB after CHAIN_LEN samples.
  assign rx_sr_d   = {rx_sr_q[CHAIN_LEN-2:0], scan_in};
  assign ph_last   = (ph_q == PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ph_q        <= '0;
      bit_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_en_q  <= 1'b0;
      shift_clk_q <= 1'b0;
      scan_out_q  <= 1'b0;
`ifdef SCAN_CAPTURE_EN
      cap_clk_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            tx_sr_q <= wr_data;
            busy_q  <= 1'b1;
            ph_q    <= '0;
`ifdef SCAN_CAPTURE_EN
            if (capture) begin
              state_q   <= ST_CAPTURE;
              cap_clk_q <= 1'b0;
            end else begin
              state_q    <= ST_SETUP;
              shift_en_q <= 1'b1;
              scan_out_q <= wr_data[CHAIN_LEN-1];
              bit_cnt_q  <= '0;
            end
`else
            state_q    <= ST_SETUP;
            shift_en_q <= 1'b1;
            scan_out_q <= wr_data[CHAIN_LEN-1];
            bit_cnt_q  <= '0;
`endif
          end
        end

`ifdef SCAN_CAPTURE_EN
        // cap_clk low for DIV cycles, then high for DIV cycles; the chain loads on its rise.
        ST_CAPTURE: begin
          if (ph_last) begin
            ph_q <= '0;
            if (!cap_clk_q) begin
              cap_clk_q <= 1'b1;
            end else begin
              cap_clk_q  <= 1'b0;
              state_q    <= ST_SETUP;
              shift_en_q <= 1'b1;
              scan_out_q <= tx_sr_q[CHAIN_LEN-1];
              bit_cnt_q  <= '0;
            end
          end else begin
            ph_q <= ph_d;
          end
        end
`endif

        ST_SETUP: begin
          state_q <= ST_SH_LO;
          ph_q    <= '0;
        end

        ST_SH_LO: begin
          if (ph_last) begin
            state_q     <= ST_SH_HI;
            ph_q        <= '0;
            shift_clk_q <= 1'b1;
            rx_sr_q     <= rx_sr_d;
          end else begin
            ph_q <= ph_d;
          end
        end

        ST_SH_HI: begin
          if (ph_last) begin
            ph_q        <= '0;
            shift_clk_q <= 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              state_q    <= ST_FINISH;
              shift_en_q <= 1'b0;
              scan_out_q <= 1'b0;
              done_q     <= 1'b1;
              rd_data_q  <= rx_sr_q;
            end else begin
              state_q    <= ST_SH_LO;
              bit_cnt_q  <= bit_cnt_d;
              tx_sr_q    <= tx_sr_d;
              scan_out_q <= tx_sr_q[CHAIN_LEN-2];
            end
          end else begin
            ph_q <= ph_d;
          end
        end

        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_data   = rd_data_q;
  assign shift_en  = shift_en_q;
  assign shift_clk = shift_clk_q;
  assign scan_out  = scan_out_q;
`ifdef SCAN_CAPTURE_EN
  assign cap_clk   = cap_clk_q;
`endif

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: behavioural 16-flop chain, cycle-index model of the op, directed scenarios.
module tb_scan_ctrl;
  localparam int N   = 16;
  localparam int DIV = 2;
  localparam int L0  = 2 + 2 * DIV * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] wr_data;
  logic         capture;
  logic         cap_clk;
  logic         busy, done, shift_en, shift_clk, scan_out, scan_in;
  logic [N-1:0] rd_data;

  int checks = 0;
  int errors = 0;

  scan_ctrl #(.CHAIN_LEN(N), .DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .wr_data   (wr_data),
`ifdef SCAN_CAPTURE_EN
    .capture   (capture),
    .cap_clk   (cap_clk),
`endif
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .shift_en  (shift_en),
    .shift_clk (shift_clk),
    .scan_out  (scan_out),
    .scan_in   (scan_in)
  );

`ifndef SCAN_CAPTURE_EN
  assign cap_clk = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural chain: position 0 is nearest scan_out, the tail feeds scan_in.
  logic [N-1:0] chain     = '0;
  logic [N-1:0] pre_val   = '0;
  logic [N-1:0] func_d    = '0;
  logic         pre_stb   = 1'b0;
  int           rise_cnt  = 0;
  int           cap_rises = 0;
  int           cap_bad   = 0;

  assign scan_in = chain[N-1];

  always @(posedge shift_clk or posedge cap_clk or posedge pre_stb) begin
    if (pre_stb) begin
      chain <= pre_val;
    end else if (cap_clk && !shift_clk) begin
      chain     <= func_d;
      cap_rises <= cap_rises + 1;
      if (shift_en) cap_bad <= cap_bad + 1;
    end else if (shift_en) begin
      chain    <= {chain[N-2:0], scan_out};
      rise_cnt <= rise_cnt + 1;
    end
  end

  // Op model: c = cycle index since accept (0 = idle; SETUP is c == m_off+1).
  int           c      = 0;
  int           m_off  = 0;
  int           rise0  = 0;
  logic         m_cap  = 1'b0;
  logic [N-1:0] m_wr   = '0;
  logic [N-1:0] m_snap = '0;
  logic [N-1:0] exp_rd = '0;
  int           m_len, k, bidx, so_idx;
  logic         e_busy, e_done, e_se, e_sclk, e_cap, e_so;

  assign m_len  = L0 + m_off;
  assign k      = c - m_off;
  assign e_busy = (c != 0);
  assign e_done = (c != 0) && (c == m_len);
  assign e_se   = (c > m_off) && (k <= L0 - 1);
  assign e_sclk = e_se && (k >= 2) && ((((k - 2) / DIV) % 2) == 1);
  assign e_cap  = m_cap && (c >= DIV + 1) && (c <= m_off);
  assign bidx   = (k < 2) ? 0 : (k - 2) / (2 * DIV);
  assign so_idx = e_se ? (N - 1 - bidx) : 0;
  assign e_so   = m_wr[so_idx];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c      <= 0;
      m_off  <= 0;
      m_cap  <= 1'b0;
      exp_rd <= '0;
    end else if (c == 0) begin
      if (start) begin
        c     <= 1;
        m_wr  <= wr_data;
        m_cap <= capture;
        m_off <= capture ? 2 * DIV : 0;
        rise0 <= rise_cnt;
        if (!capture) m_snap <= chain;
      end
    end else if (c == m_len) begin
      c <= 0;
    end else begin
      c <= c + 1;
      if (m_cap && (c == m_off)) m_snap <= chain;
      if (c + 1 == m_len) exp_rd <= m_snap;
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("shift_en", shift_en, e_se);
    chk("shift_clk", shift_clk, e_sclk);
    chk("cap_clk", cap_clk, e_cap);
    chk("rd_data", rd_data, exp_rd);
    if (e_se) chk("scan_out", scan_out, e_so);
    if (e_done) begin
      chk("chain_loaded", chain, m_wr);
      chk("rise_count", rise_cnt - rise0, N);
    end
  end

  task automatic preload(input logic [N-1:0] v);
    pre_val = v;
    #1 pre_stb = 1'b1;
    #1 pre_stb = 1'b0;
  endtask

  // Returns n = cycle in which done was seen (SETUP is cycle 1); pulse_at pulses start mid-op.
  task automatic run_op(input logic [N-1:0] w, input logic cap, input int pulse_at,
                        output int n, output logic idle_busy);
    @(posedge clk); #1;
    start   = 1'b1;
    wr_data = w;
    capture = cap;
    @(negedge clk);
    idle_busy = busy;
    @(posedge clk); #1;
    start   = 1'b0;
    capture = 1'b0;
    wr_data = ~w;
    n = 1;
    @(negedge clk);
    while (!done && n < 200) begin
      start = (n == pulse_at);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", done, 1'b1);
  endtask

  int   n, base, extra, cbase;
  logic ib;

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_data = '0; capture = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_shift_en", shift_en, 1'b0);
    chk("rst_shift_clk", shift_clk, 1'b0);
    chk("rst_scan_out", scan_out, 1'b0);
    chk("rst_rd_data", rd_data, 16'h0000);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_busy", busy, 1'b0);

    // Preloaded chain read back while the new word is loaded.
    preload(16'h1234);
    base = rise_cnt;
    run_op(16'hA5C3, 1'b0, 0, n, ib);
    chk("t2_latency", n, 66);
    chk("t2_rd", rd_data, 16'h1234);
    chk("t2_chain", chain, 16'hA5C3);
    chk("t2_rises", rise_cnt - base, 16);

    // Back-to-back ops with one idle cycle between them.
    run_op(16'hFFFF, 1'b0, 0, n, ib);
    chk("t3a_idle", ib, 1'b0);
    chk("t3a_rd", rd_data, 16'hA5C3);
    run_op(16'h0001, 1'b0, 0, n, ib);
    chk("t3b_idle", ib, 1'b0);
    chk("t3b_latency", n, 66);
    chk("t3b_rd", rd_data, 16'hFFFF);
    chk("t3b_chain", chain, 16'h0001);

    // start pulsed during bit 7 (cycle 31) is dropped.
    base = rise_cnt;
    run_op(16'h3C5A, 1'b0, 31, n, ib);
    chk("t4_latency", n, 66);
    chk("t4_rd", rd_data, 16'h0001);
    chk("t4_rises", rise_cnt - base, 16);
    extra = 0;
    repeat (80) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("t4_extra_done", extra, 0);
    chk("t4_busy_after", busy, 1'b0);

    // Reset after 5 shift_clk rises aborts the op.
    base = rise_cnt;
    @(posedge clk); #1;
    start = 1'b1; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while ((rise_cnt - base) < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_pre_sclk", shift_clk, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_sclk", shift_clk, 1'b0);
    chk("t5_se", shift_en, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_rd", rd_data, 16'h0000);
    chk("t5_chain", chain, 16'h8B57);
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(16'h8421, 1'b0, 0, n, ib);
    chk("t5_latency", n, 66);
    chk("t5_rd_after", rd_data, 16'h8B57);
    chk("t5_chain_after", chain, 16'h8421);

`ifdef SCAN_CAPTURE_EN
    func_d = 16'h00F0;
    cbase  = cap_rises;
    run_op(16'h1357, 1'b1, 0, n, ib);
    chk("t6_latency", n, 70);
    chk("t6_rd", rd_data, 16'h00F0);
    chk("t6_chain", chain, 16'h1357);
    chk("t6_cap_pulses", cap_rises - cbase, 1);
    chk("t6_cap_se", cap_bad, 0);
`else
    cbase = 0;
`endif

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
